// File: rtl/reg_write_queue.sv
// rtl/reg_write_queue.sv - in-order register-file writeback queue fed by memory and ALU
module reg_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        memValid,
    input  logic [2:0]  memDest,
    input  logic [15:0] memData,
    input  logic        aluValid,
    input  logic [2:0]  aluDest,
    input  logic [15:0] aluData,
    input  logic        drainEn,
    output logic        memReady,
    output logic        aluReady,
    output logic        regWrite,
    output logic [2:0]  regDest,
    output logic [15:0] DataWrite,
    output logic [7:0]  busyMask,
    output logic [3:0]  count
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [3:0]  FULL  = 4'(DEPTH);

    logic [2:0]       destMem [DEPTH];
    logic [15:0]      dataMem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] offset;
    logic             notFull;
    logic             push;
    logic [2:0]       pushDest;
    logic [15:0]      pushData;

    // Acceptance uses only the registered count; memory always wins over the ALU.
    always_comb begin
        notFull  = !RST && (count < FULL);
        memReady = memValid && notFull;
        aluReady = aluValid && !memValid && notFull;
        push     = memReady || aluReady;
        pushDest = memValid ? memDest : aluDest;
        pushData = memValid ? memData : aluData;
    end

    // Head entry presented to the register file; zeros while the queue is empty.
    always_comb begin
        regWrite  = drainEn && (count != 4'd0);
        regDest   = 3'd0;
        DataWrite = 16'd0;
        if (count != 4'd0) begin
            regDest   = destMem[rdPtr];
            DataWrite = dataMem[rdPtr];
        end
    end

    // Entry i is live when its distance from the head is below count.
    always_comb begin
        busyMask = 8'd0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rdPtr;
            if (4'(offset) < count) begin
                busyMask[destMem[i]] = 1'b1;
            end
        end
    end

    // Storage is not reset; liveness comes entirely from the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) begin
            destMem[wrPtr] <= pushDest;
            dataMem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; push and pop may coincide.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= 4'd0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (regWrite) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, regWrite})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
